// File: rtl/video_pkg.sv
// video_pkg: shared frame geometry, widths, result record and centre helper
// for the binary video measurement path.
package video_pkg;
   localparam int COORD_W = 10;
   localparam int CNT_W   = 17;
   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   localparam coord_t IMG_HDISP_DEF  = 10'd320;
   localparam coord_t IMG_VDISP_DEF  = 10'd240;
   localparam cnt_t   MIN_PIXELS_DEF = 17'd64;
   typedef struct packed {
      coord_t xmin;
      coord_t xmax;
      coord_t ymin;
      coord_t ymax;
      coord_t xc;
      coord_t yc;
      cnt_t   cnt;
      logic   valid;
   } result_t;
   function automatic coord_t mid(input coord_t a, input coord_t b);
      logic [COORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[COORD_W:1];
   endfunction
endpackage

// File: rtl/binary_target_locator_if.sv
// binary_target_locator_if: 1-bit video stream in, per-frame target result out.
interface binary_target_locator_if;
   import video_pkg::*;
   logic   per_frame_vsync;
   logic   per_frame_href;
   logic   per_frame_clken;
   logic   per_img_Bit;
   coord_t target_xmin;
   coord_t target_xmax;
   coord_t target_ymin;
   coord_t target_ymax;
   coord_t target_xcenter;
   coord_t target_ycenter;
   cnt_t   target_pixel_cnt;
   logic   target_valid;
   logic   result_update;
   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
      input  target_xmin, target_xmax, target_ymin, target_ymax,
      input  target_xcenter, target_ycenter, target_pixel_cnt, target_valid, result_update
   );
   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
      output target_xmin, target_xmax, target_ymin, target_ymax,
      output target_xcenter, target_ycenter, target_pixel_cnt, target_valid, result_update
   );
endinterface

// File: rtl/video_xy_counter.sv
// video_xy_counter: vsync/href edge detection and pixel column/row position.
module video_xy_counter
   import video_pkg::*;
#(
   parameter coord_t H = IMG_HDISP_DEF,
   parameter coord_t V = IMG_VDISP_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   vsync,
   input  logic   href,
   input  logic   clken,
   output logic   frame_start,
   output logic   frame_end,
   output logic   pix_valid,
   output coord_t x,
   output coord_t y
);
   logic   vsync_q, href_q;
   coord_t x_q, x_d, y_q, y_d;
   always_comb begin
      frame_start = vsync & ~vsync_q;
      frame_end   = ~vsync & vsync_q;
      x_d = !href ? '0 : (clken && x_q < H) ? x_q + 1'b1 : x_q;
      y_d = frame_start ? '0 : (vsync && href_q && !href && y_q < V) ? y_q + 1'b1 : y_q;
      x = x_q;
      y = frame_start ? '0 : y_q;
      pix_valid = vsync & href & clken & (x < H) & (y < V);
   end
   // vsync_q resets high so a frame already running at reset release never looks like a start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         vsync_q <= vsync;
         href_q  <= href;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end
endmodule

// File: rtl/binary_target_locator.sv
// binary_target_locator: per-frame bounding box, centre and pixel count of the
// foreground blob, latched once per frame for the arm controller.
module binary_target_locator
   import video_pkg::*;
#(
   parameter coord_t IMG_HDISP  = IMG_HDISP_DEF,
   parameter coord_t IMG_VDISP  = IMG_VDISP_DEF,
   parameter cnt_t   MIN_PIXELS = MIN_PIXELS_DEF
) (
   input logic clk,
   input logic rst_n,
   binary_target_locator_if.slave bus
);
   logic    frame_start, frame_end, pix_valid, hit;
   coord_t  x, y;
   logic    armed_q, armed_d, end_q, end_d, upd_q, upd_d;
   coord_t  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   coord_t  xmin_b, xmax_b, ymin_b, ymax_b;
   cnt_t    cnt_q, cnt_d, cnt_b;
   result_t res_q, res_d;
   video_xy_counter #(.H(IMG_HDISP), .V(IMG_VDISP)) u_xy (
      .clk         (clk),
      .rst_n       (rst_n),
      .vsync       (bus.per_frame_vsync),
      .href        (bus.per_frame_href),
      .clken       (bus.per_frame_clken),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .pix_valid   (pix_valid),
      .x           (x),
      .y           (y)
   );
   // accumulators restart on frame start, yet still take a pixel arriving in that cycle
   always_comb begin
      armed_d = armed_q | frame_start;
      hit     = armed_d & pix_valid & bus.per_img_Bit;
      xmin_b  = frame_start ? '1 : xmin_q;
      xmax_b  = frame_start ? '0 : xmax_q;
      ymin_b  = frame_start ? '1 : ymin_q;
      ymax_b  = frame_start ? '0 : ymax_q;
      cnt_b   = frame_start ? '0 : cnt_q;
      xmin_d  = (hit && x < xmin_b) ? x : xmin_b;
      xmax_d  = (hit && x > xmax_b) ? x : xmax_b;
      ymin_d  = (hit && y < ymin_b) ? y : ymin_b;
      ymax_d  = (hit && y > ymax_b) ? y : ymax_b;
      cnt_d   = (hit && cnt_b != '1) ? cnt_b + 1'b1 : cnt_b;
      end_d   = frame_end & armed_q;
      upd_d   = end_q;
      res_d   = !end_q ? res_q :
                (cnt_q == '0) ? '0 :
                result_t'{xmin: xmin_q, xmax: xmax_q, ymin: ymin_q, ymax: ymax_q,
                          xc: mid(xmin_q, xmax_q), yc: mid(ymin_q, ymax_q),
                          cnt: cnt_q, valid: (cnt_q >= MIN_PIXELS)};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         end_q   <= 1'b0;
         upd_q   <= 1'b0;
         xmin_q  <= '1;
         xmax_q  <= '0;
         ymin_q  <= '1;
         ymax_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         armed_q <= armed_d;
         end_q   <= end_d;
         upd_q   <= upd_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end
   assign bus.target_xmin      = res_q.xmin;
   assign bus.target_xmax      = res_q.xmax;
   assign bus.target_ymin      = res_q.ymin;
   assign bus.target_ymax      = res_q.ymax;
   assign bus.target_xcenter   = res_q.xc;
   assign bus.target_ycenter   = res_q.yc;
   assign bus.target_pixel_cnt = res_q.cnt;
   assign bus.target_valid     = res_q.valid;
   assign bus.result_update    = upd_q;
endmodule

// File: tb/tb_binary_target_locator.sv
// tb_binary_target_locator: frame-level stimulus with a scoreboard of expected
// per-frame results popped on each result_update.
module tb_binary_target_locator;
   import video_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   binary_target_locator_if bus();
   binary_target_locator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      int xmin, xmax, ymin, ymax, xc, yc, cnt, valid, fall;
   } exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0, cyc = 0, n_upd = 0, n_exp = 0;
   int nr = 0;
   int rx0[2], rx1[2], ry0[2], ry1[2];
   int px[$], py[$];
   bit stray = 1'b0;
   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask
   function automatic bit fg(input int x, input int y);
      for (int i = 0; i < nr; i++)
         if (x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i]) return 1'b1;
      for (int i = 0; i < px.size(); i++)
         if (x == px[i] && y == py[i]) return 1'b1;
      return stray && y == 0 && x == 320;
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (bus.result_update) begin
         n_upd++;
         if (sb.size() == 0) check("update_without_frame", sb.size(), 1);
         else begin
            e = sb.pop_front();
            check("latency", cyc - e.fall, 2);
            check("xmin", int'(bus.target_xmin), e.xmin);
            check("xmax", int'(bus.target_xmax), e.xmax);
            check("ymin", int'(bus.target_ymin), e.ymin);
            check("ymax", int'(bus.target_ymax), e.ymax);
            check("xcenter", int'(bus.target_xcenter), e.xc);
            check("ycenter", int'(bus.target_ycenter), e.yc);
            check("pixel_cnt", int'(bus.target_pixel_cnt), e.cnt);
            check("valid", int'(bus.target_valid), e.valid);
         end
      end
   end
   task automatic px_cycle(input bit h, input bit c, input bit b);
      bus.per_frame_href  = h;
      bus.per_frame_clken = c;
      bus.per_img_Bit     = b;
      @(negedge clk);
   endtask
   task automatic run_frame(input bit rst_mid);
      int xmin = 1023, xmax = 0, ymin = 1023, ymax = 0, cnt = 0, last;
      exp_t e;
      if (stray) begin
         px_cycle(1, 1, 1);
         px_cycle(1, 1, 1);
         px_cycle(0, 0, 0);
      end
      bus.per_frame_vsync = 1'b1;
      px_cycle(0, 0, 0);
      px_cycle(0, 0, 0);
      for (int y = 0; y < 240; y++) begin
         last = -1;
         for (int x = 0; x <= 320; x++) if (fg(x, y)) last = x;
         if (last < 0) px_cycle(1, 0, 0);
         for (int x = 0; x <= last; x++) begin
            if (x == 3) px_cycle(1, 0, 1);
            px_cycle(1, 1, fg(x, y));
            if (fg(x, y) && x < 320) begin
               cnt++;
               if (x < xmin) xmin = x;
               if (x > xmax) xmax = x;
               if (y < ymin) ymin = y;
               if (y > ymax) ymax = y;
            end
         end
         px_cycle(0, 0, 0);
         px_cycle(0, 0, 0);
         if (rst_mid && y == 20) begin
            rst_n = 1'b0;
            #1;
            check("rst_mid_cnt", int'(bus.target_pixel_cnt), 0);
            check("rst_mid_xmax", int'(bus.target_xmax), 0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      bus.per_frame_vsync = 1'b0;
      if (!rst_mid) begin
         if (cnt == 0) e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
         else e = '{xmin, xmax, ymin, ymax, (xmin + xmax) / 2, (ymin + ymax) / 2,
                    cnt, int'(cnt >= 64), 0};
         e.fall = cyc;
         sb.push_back(e);
         n_exp++;
      end
      repeat (6) @(negedge clk);
      check("update_count", n_upd, n_exp);
   endtask
   task automatic set_rect(input int i, input int x0, input int x1, input int y0, input int y1);
      rx0[i] = x0; rx1[i] = x1; ry0[i] = y0; ry1[i] = y1;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog cycles=%0d limit=200000", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      bus.per_img_Bit     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_xmin", int'(bus.target_xmin), 0);
      check("reset_ycenter", int'(bus.target_ycenter), 0);
      check("reset_cnt", int'(bus.target_pixel_cnt), 0);
      check("reset_valid", int'(bus.target_valid), 0);
      check("reset_update", int'(bus.result_update), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      nr = 1; set_rect(0, 100, 109, 50, 54);
      run_frame(1'b0);
      set_rect(0, 100, 109, 50, 59);
      run_frame(1'b0);
      nr = 0;
      run_frame(1'b0);
      nr = 1; set_rect(0, 10, 20, 10, 20);
      run_frame(1'b0);
      set_rect(0, 300, 319, 200, 239);
      run_frame(1'b0);
      nr = 0; stray = 1'b1;
      px.push_back(0);   py.push_back(0);
      px.push_back(319); py.push_back(239);
      run_frame(1'b0);
      stray = 1'b0; px.delete(); py.delete();
      nr = 2; set_rect(0, 100, 109, 50, 54); set_rect(1, 200, 203, 5, 8);
      run_frame(1'b1);
      run_frame(1'b0);
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
